// File: rtl/nn_pkg.sv
// Shared types and sizes for the MVM accumulate/quantise stage.
// DIM and NUM_BIT must match the MVM instance this stage sits behind.
package nn_pkg;
  localparam int DIM      = 4;
  localparam int NUM_BIT  = 4;
  localparam int NBIT_MAX = (1 << NUM_BIT) - 1;

  typedef logic [NUM_BIT-1:0] nbit_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;
endpackage

// File: rtl/mvm_acc_quant_if.sv
// Bundle of MVM-facing inputs and the valid/ready result port of mvm_acc_quant.
// Handshake: o_y_acc transfers on a cycle with o_valid_acc && i_ready_acc; while o_valid_acc && !i_ready_acc, o_y_acc and o_valid_acc hold.
interface mvm_acc_quant_if import nn_pkg::*; #(
  parameter int NUM_TERMS = 4
);
  localparam int TERM_W = $clog2(NUM_TERMS) + 1;

  logic              i_ismvm_acc;
  nbit_t [DIM-1:0]   i_wx_acc;
  logic              i_clear_acc;
  logic              i_ready_acc;
  logic              o_valid_acc;
  nbit_t [DIM-1:0]   o_y_acc;
  logic [TERM_W-1:0] o_term_acc;
  logic              o_overrun_acc;
  acc_state_e        o_state_acc;

  modport master (
    output i_ismvm_acc, i_wx_acc, i_clear_acc, i_ready_acc,
    input  o_valid_acc, o_y_acc, o_term_acc, o_overrun_acc, o_state_acc
  );

  modport slave (
    input  i_ismvm_acc, i_wx_acc, i_clear_acc, i_ready_acc,
    output o_valid_acc, o_y_acc, o_term_acc, o_overrun_acc, o_state_acc
  );
endinterface

// File: rtl/mvm_acc_quant_lane.sv
// One lane: snapshot of the cumulative MVM counter, modular delta, accumulator
// and the shift/saturate view of the post-capture accumulator value.
module acc_lane import nn_pkg::*; #(
  parameter int ACC_BIT = 8,
  parameter int SHIFT   = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  capture,
  input  logic  clear,
  input  logic  last,
  input  nbit_t wx_i,
  output nbit_t y_o
);
  nbit_t              snap_q, snap_d;
  logic [ACC_BIT-1:0] acc_q, acc_d;
  nbit_t              delta;
  logic [ACC_BIT-1:0] acc_sum;
  logic [ACC_BIT-1:0] q;

  // The counter is never cleared by the MVM, so the NUM_BIT-wide subtraction
  // wraps naturally and yields the per-pass increment.
  assign delta   = wx_i - snap_q;
  assign acc_sum = acc_q + ACC_BIT'(delta);
  assign q       = acc_sum >> SHIFT;

  always_comb begin
    y_o = q[NUM_BIT-1:0];
    if (q > ACC_BIT'(NBIT_MAX)) y_o = nbit_t'(NBIT_MAX);
  end

  always_comb begin
    snap_d = snap_q;
    acc_d  = acc_q;
    if (clear) begin
      snap_d = '0;
      acc_d  = '0;
    end else if (capture) begin
      snap_d = wx_i;
      acc_d  = last ? '0 : acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q <= '0;
      acc_q  <= '0;
    end else begin
      snap_q <= snap_d;
      acc_q  <= acc_d;
    end
  end
endmodule

// File: rtl/mvm_acc_quant.sv
// Accumulates NUM_TERMS MVM passes per lane, then offers the shifted and
// saturated vector on a valid/ready port; a group finishing while held is dropped.
module mvm_acc_quant import nn_pkg::*; #(
  parameter int NUM_TERMS = 4,
  parameter int ACC_BIT   = 8,
  parameter int SHIFT     = 2
) (
  input  logic            i_clk_acc,
  input  logic            i_rst_n_acc,
  mvm_acc_quant_if.slave  acc_if
);
  localparam int TERM_W = $clog2(NUM_TERMS) + 1;

  logic              ismvm_q;
  logic              capture;
  logic              complete;
  logic [TERM_W-1:0] term_q, term_d;
  acc_state_e        state_q, state_d;
  logic              valid_q, valid_d;
  nbit_t [DIM-1:0]   y_q, y_d;
  logic              overrun_q, overrun_d;
  nbit_t [DIM-1:0]   lane_y;

  // Flush wins over a coincident capture, so the capture is masked here.
  assign capture  = ismvm_q && !acc_if.i_ismvm_acc && !acc_if.i_clear_acc;
  assign complete = capture && (term_q == TERM_W'(NUM_TERMS - 1));

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    acc_lane #(
      .ACC_BIT (ACC_BIT),
      .SHIFT   (SHIFT)
    ) u_lane (
      .clk     (i_clk_acc),
      .rst_n   (i_rst_n_acc),
      .capture (capture),
      .clear   (acc_if.i_clear_acc),
      .last    (complete),
      .wx_i    (acc_if.i_wx_acc[g]),
      .y_o     (lane_y[g])
    );
  end

  always_comb begin
    term_d = term_q;
    if (acc_if.i_clear_acc)  term_d = '0;
    else if (complete)       term_d = '0;
    else if (capture)        term_d = term_q + 1'b1;
  end

  always_ff @(posedge i_clk_acc) begin
    if (!i_rst_n_acc) begin
      ismvm_q   <= 1'b0;
      term_q    <= '0;
      state_q   <= ACCUM;
      valid_q   <= 1'b0;
      y_q       <= '0;
      overrun_q <= 1'b0;
    end else begin
      ismvm_q   <= acc_if.i_ismvm_acc;
      term_q    <= term_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      y_q       <= y_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (complete) state_d = HOLD;
      HOLD:    if (acc_if.i_ready_acc && !complete) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // A result loads when the port is free or is being drained this cycle;
  // otherwise a finished group is dropped and flagged.
  always_comb begin
    valid_d   = (state_d == HOLD);
    y_d       = y_q;
    overrun_d = 1'b0;
    if (complete) begin
      if (state_q == ACCUM || acc_if.i_ready_acc) y_d = lane_y;
      else                                        overrun_d = 1'b1;
    end
  end

  assign acc_if.o_valid_acc   = valid_q;
  assign acc_if.o_y_acc       = y_q;
  assign acc_if.o_term_acc    = term_q;
  assign acc_if.o_overrun_acc = overrun_q;
  assign acc_if.o_state_acc   = state_q;
endmodule

// File: tb/tb_mvm_acc_quant.sv
// Directed bench for mvm_acc_quant: instance a uses SHIFT=2, instance b uses
// SHIFT=0 on identical stimulus so saturation becomes reachable.
module tb_mvm_acc_quant;
  import nn_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  mvm_acc_quant_if #(.NUM_TERMS(4)) ifa ();
  mvm_acc_quant_if #(.NUM_TERMS(4)) ifb ();

  assign ifb.i_ismvm_acc = ifa.i_ismvm_acc;
  assign ifb.i_wx_acc    = ifa.i_wx_acc;
  assign ifb.i_clear_acc = ifa.i_clear_acc;
  assign ifb.i_ready_acc = ifa.i_ready_acc;

  mvm_acc_quant #(.NUM_TERMS(4), .ACC_BIT(8), .SHIFT(2)) dut_a (
    .i_clk_acc   (clk),
    .i_rst_n_acc (rst_n),
    .acc_if      (ifa.slave)
  );

  mvm_acc_quant #(.NUM_TERMS(4), .ACC_BIT(8), .SHIFT(0)) dut_b (
    .i_clk_acc   (clk),
    .i_rst_n_acc (rst_n),
    .acc_if      (ifb.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One MVM pass: busy for 1..3 cycles with junk counter values, then the
  // first idle cycle presents the counter reading (the capture cycle).
  task automatic mvm_pass(input logic [15:0] wx, input logic rdy, input logic clr);
    int n;
    n = $urandom_range(1, 3);
    ifa.i_ismvm_acc = 1'b1;
    repeat (n) begin
      ifa.i_wx_acc = 16'($urandom);
      @(posedge clk);
      #1;
    end
    ifa.i_ismvm_acc = 1'b0;
    ifa.i_wx_acc    = wx;
    ifa.i_ready_acc = rdy;
    ifa.i_clear_acc = clr;
    @(posedge clk);
    #1;
    ifa.i_ready_acc = 1'b0;
    ifa.i_clear_acc = 1'b0;
    ifa.i_wx_acc    = 16'($urandom);
  endtask

  task automatic accept();
    ifa.i_ready_acc = 1'b1;
    @(posedge clk);
    #1;
    ifa.i_ready_acc = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(ifa.o_valid_acc),   32'd0);
    check({tag, "_y"},       32'(ifa.o_y_acc),       32'd0);
    check({tag, "_term"},    32'(ifa.o_term_acc),    32'd0);
    check({tag, "_overrun"}, 32'(ifa.o_overrun_acc), 32'd0);
    check({tag, "_state"},   32'(ifa.o_state_acc),   32'(ACCUM));
    check({tag, "_y_b"},     32'(ifb.o_y_acc),       32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    ifa.i_ismvm_acc = 1'b1;
    ifa.i_wx_acc    = 16'h5A5A;
    ifa.i_clear_acc = 1'b0;
    ifa.i_ready_acc = 1'b0;
    idle(3);
    ifa.i_ismvm_acc = 1'b0;
    idle(1);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    // Group 1: lane0 3,7,12,15; lane3 exercises the 14 -> 2 wrap.
    mvm_pass(16'hEF13, 1'b0, 1'b0);
    check("g1_term1", 32'(ifa.o_term_acc), 32'd1);
    mvm_pass(16'h2F27, 1'b0, 1'b0);
    check("g1_term2", 32'(ifa.o_term_acc), 32'd2);
    mvm_pass(16'h6F3C, 1'b0, 1'b0);
    check("g1_term3", 32'(ifa.o_term_acc), 32'd3);
    check("g1_valid_before", 32'(ifa.o_valid_acc), 32'd0);
    mvm_pass(16'hAF4F, 1'b0, 1'b0);
    check("g1_valid", 32'(ifa.o_valid_acc), 32'd1);
    check("g1_y_a", 32'(ifa.o_y_acc), 32'h6313);
    check("g1_y_b", 32'(ifb.o_y_acc), 32'hFF4F);
    check("g1_term0", 32'(ifa.o_term_acc), 32'd0);
    check("g1_state", 32'(ifa.o_state_acc), 32'(HOLD));
    check("g1_no_overrun", 32'(ifa.o_overrun_acc), 32'd0);
    idle(2);
    check("g1_hold_valid", 32'(ifa.o_valid_acc), 32'd1);
    check("g1_hold_y", 32'(ifa.o_y_acc), 32'h6313);
    accept();
    check("g1_accept_valid", 32'(ifa.o_valid_acc), 32'd0);
    check("g1_accept_state", 32'(ifa.o_state_acc), 32'(ACCUM));

    // Group 2: delta 15 on every lane four times, acc = 60.
    mvm_pass(16'h9E3E, 1'b0, 1'b0);
    mvm_pass(16'h8D2D, 1'b0, 1'b0);
    mvm_pass(16'h7C1C, 1'b0, 1'b0);
    mvm_pass(16'h6B0B, 1'b0, 1'b0);
    check("g2_valid", 32'(ifa.o_valid_acc), 32'd1);
    check("g2_y_a", 32'(ifa.o_y_acc), 32'hFFFF);
    check("g2_sat_y_b", 32'(ifb.o_y_acc), 32'hFFFF);

    // Group 3 completes while group 2 is still held: dropped, overrun pulse.
    mvm_pass(16'h7C1C, 1'b0, 1'b0);
    mvm_pass(16'h8D2D, 1'b0, 1'b0);
    mvm_pass(16'h9E3E, 1'b0, 1'b0);
    check("g3_no_overrun_yet", 32'(ifa.o_overrun_acc), 32'd0);
    mvm_pass(16'hAF4F, 1'b0, 1'b0);
    check("g3_overrun", 32'(ifa.o_overrun_acc), 32'd1);
    check("g3_overrun_b", 32'(ifb.o_overrun_acc), 32'd1);
    check("g3_y_kept", 32'(ifa.o_y_acc), 32'hFFFF);
    check("g3_valid", 32'(ifa.o_valid_acc), 32'd1);
    check("g3_term0", 32'(ifa.o_term_acc), 32'd0);
    idle(1);
    check("g3_overrun_1cyc", 32'(ifa.o_overrun_acc), 32'd0);

    // Group 4: ready arrives in the same cycle as completion.
    mvm_pass(16'h2581, 1'b0, 1'b0);
    mvm_pass(16'hABC3, 1'b0, 1'b0);
    mvm_pass(16'h2105, 1'b0, 1'b0);
    check("g4_y_pre", 32'(ifa.o_y_acc), 32'hFFFF);
    mvm_pass(16'hA747, 1'b1, 1'b0);
    check("g4_valid", 32'(ifa.o_valid_acc), 32'd1);
    check("g4_state", 32'(ifa.o_state_acc), 32'(HOLD));
    check("g4_y_a", 32'(ifa.o_y_acc), 32'h8642);
    check("g4_y_b", 32'(ifb.o_y_acc), 32'hFFF8);
    check("g4_no_overrun", 32'(ifa.o_overrun_acc), 32'd0);

    // Clear mid-group, coincident with a capture; output stays pending.
    mvm_pass(16'hB858, 1'b0, 1'b0);
    mvm_pass(16'hC969, 1'b0, 1'b0);
    check("clr_term2", 32'(ifa.o_term_acc), 32'd2);
    mvm_pass(16'hF0F0, 1'b0, 1'b1);
    check("clr_term0", 32'(ifa.o_term_acc), 32'd0);
    check("clr_valid_kept", 32'(ifa.o_valid_acc), 32'd1);
    check("clr_y_kept", 32'(ifa.o_y_acc), 32'h8642);
    accept();
    mvm_pass(16'h1111, 1'b0, 1'b0);
    mvm_pass(16'h2222, 1'b0, 1'b0);
    mvm_pass(16'h3333, 1'b0, 1'b0);
    mvm_pass(16'h4444, 1'b0, 1'b0);
    check("clr_snap_y_a", 32'(ifa.o_y_acc), 32'h1111);
    check("clr_snap_y_b", 32'(ifb.o_y_acc), 32'h4444);

    // Reset mid-group with an output pending.
    mvm_pass(16'h5555, 1'b0, 1'b0);
    mvm_pass(16'h6666, 1'b0, 1'b0);
    check("rst_pre_term2", 32'(ifa.o_term_acc), 32'd2);
    rst_n = 1'b0;
    idle(2);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    idle(1);
    mvm_pass(16'h2222, 1'b0, 1'b0);
    mvm_pass(16'h4444, 1'b0, 1'b0);
    mvm_pass(16'h6666, 1'b0, 1'b0);
    mvm_pass(16'h8888, 1'b0, 1'b0);
    check("post_rst_valid", 32'(ifa.o_valid_acc), 32'd1);
    check("post_rst_y_a", 32'(ifa.o_y_acc), 32'h2222);
    check("post_rst_y_b", 32'(ifb.o_y_acc), 32'h8888);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
